// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: state encoding and memory sizing.
// Imported by the loader, the CPU top level and the testbench.
package inst_loader_pkg;

  localparam int DEPTH_DEFAULT  = 64;
  localparam int ADDR_W_DEFAULT = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: a 2-bit byte counter plus a right-shifting
// register, so the first byte of a word lands in bits [7:0] and the fourth in [31:24].
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_last,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [31:0] shreg;

  // The completed word is presented combinationally so the loader can register
  // it in the same cycle the fourth byte is transferred.
  assign word_last = byte_en && (byte_cnt == 2'd3);
  assign word      = {byte_data, shreg[31:8]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      shreg    <= 32'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      shreg    <= 32'd0;
    end else if (byte_en) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= word;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Streams a length-prefixed, checksummed byte image into instruction memory,
// holding the CPU (busy) while the load is in progress.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t            state;
  logic [ADDR_W-1:0] word_idx;
  logic [7:0]        words_left;
  logic [7:0]        csum;

  logic              xfer;
  logic              can_start;
  logic              pack_clear;
  logic              pack_en;
  logic              word_last;
  logic [31:0]       packed_word;

  assign xfer       = byte_valid && byte_ready;
  assign can_start  = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
  assign pack_clear = start && can_start;
  assign pack_en    = xfer && (state == ST_DATA);

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pack_clear),
    .byte_en   (pack_en),
    .byte_data (byte_data),
    .word_last (word_last),
    .word      (packed_word)
  );

  // byte_ready and busy are registered alongside the state so they change on the
  // same edge the FSM enters or leaves LEN/DATA/CSUM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      word_idx   <= '0;
      words_left <= 8'd0;
      csum       <= 8'd0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state      <= ST_LEN;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_idx   <= '0;
            words_left <= 8'd0;
            csum       <= 8'd0;
          end
        end

        ST_LEN: begin
          if (xfer) begin
            if (int'(byte_data) > DEPTH) begin
              state      <= ST_ERR;
              error      <= 1'b1;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
            end else if (byte_data == 8'd0) begin
              state <= ST_CSUM;
            end else begin
              state      <= ST_DATA;
              words_left <= byte_data;
            end
          end
        end

        ST_DATA: begin
          if (xfer) begin
            csum <= csum + byte_data;
            // N <= DEPTH <= 2**ADDR_W, so word_idx never reaches DEPTH here.
            if (word_last) begin
              mem_we     <= 1'b1;
              mem_addr   <= word_idx;
              mem_wdata  <= packed_word;
              word_idx   <= word_idx + ADDR_W'(1);
              words_left <= words_left - 8'd1;
              if (words_left == 8'd1) state <= ST_CSUM;
            end
          end
        end

        ST_CSUM: begin
          if (xfer) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            if (byte_data == csum) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
        end

        default: begin
          state      <= ST_IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
